// File: rtl/gray_counter_pkg.sv
// Shared types and Gray-code helpers for the gray_counter slice.
// The helpers work on a fixed 32-bit container. Narrower counts are zero-extended
// on the way in and truncated on the way out.
package gray_pkg;

  localparam int CNT_DW = 6;
  localparam int MAX_DW = 32;

  typedef logic [CNT_DW-1:0] cnt_t;

  // Binary to reflected Gray: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [MAX_DW-1:0] bin2gray(input logic [MAX_DW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: bit i is the XOR of all Gray bits at i and above.
  // This is built as a prefix XOR by doubling the shift distance.
  function automatic logic [MAX_DW-1:0] gray2bin(input logic [MAX_DW-1:0] g);
    logic [MAX_DW-1:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_bin2gray.sv
// Combinational binary-to-Gray converter.
// It sits between the next-state binary value and the Gray register.
module Bin2Gray #(
  parameter int DW = 6
) (
  input  logic [DW-1:0] bin,
  output logic [DW-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Parametrised up/down counter with registered binary and Gray outputs kept in lockstep.
// The Gray value is taken from the next-state binary, so both registers load on the same edge.
// It provides load, enable, direction, wrap/saturate mode and a one-cycle wrap pulse.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned DW       = 6,
  parameter int unsigned INIT     = 0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          up,
  input  logic          ld,
  input  logic [DW-1:0] ld_val,
  output logic [DW-1:0] bin,
  output logic [DW-1:0] gray,
  output logic          wrap,
  output logic          at_max,
  output logic          at_min
);

  localparam logic [DW-1:0] MAX_VAL   = {DW{1'b1}};
  localparam logic [DW-1:0] MIN_VAL   = '0;
  localparam logic [DW-1:0] ONE       = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] INIT_BIN  = DW'(INIT);
  localparam logic [DW-1:0] INIT_GRAY = DW'(bin2gray(MAX_DW'(INIT_BIN)));

  logic [DW-1:0] bin_next;
  logic [DW-1:0] gray_next;
  logic          wrap_next;

  // Next-state binary and wrap flag; load beats enable, and the ends either wrap or hold.
  always_comb begin
    bin_next  = bin;
    wrap_next = 1'b0;
    if (ld) begin
      bin_next = ld_val;
    end else if (en) begin
      if (up) begin
        if (bin == MAX_VAL) begin
          if (SATURATE) begin
            bin_next = bin;
          end else begin
            bin_next  = MIN_VAL;
            wrap_next = 1'b1;
          end
        end else begin
          bin_next = bin + ONE;
        end
      end else begin
        if (bin == MIN_VAL) begin
          if (SATURATE) begin
            bin_next = bin;
          end else begin
            bin_next  = MAX_VAL;
            wrap_next = 1'b1;
          end
        end else begin
          bin_next = bin - ONE;
        end
      end
    end
  end

  Bin2Gray #(.DW(DW)) u_bin2gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // Count state registers; reset restores INIT and also kills any pending wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= INIT_BIN;
      gray <= INIT_GRAY;
      wrap <= 1'b0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
      wrap <= wrap_next;
    end
  end

  assign at_max = (bin == MAX_VAL);
  assign at_min = (bin == MIN_VAL);

endmodule

// File: tb/tb_gray_counter.sv
// Directed and randomised checks for gray_counter.
// It drives a wrapping instance and a saturating instance from shared inputs.
module tb_gray_counter;
  import gray_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       ld;
  logic [5:0] ld_val;

  logic [5:0] w_bin, w_gray, s_bin, s_gray;
  logic       w_wrap, w_at_max, w_at_min;
  logic       s_wrap, s_at_max, s_at_min;

  int compare_count = 0;
  int fail_count    = 0;

  gray_counter #(.DW(6), .INIT(0), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .ld_val(ld_val),
    .bin(w_bin), .gray(w_gray), .wrap(w_wrap), .at_max(w_at_max), .at_min(w_at_min)
  );

  gray_counter #(.DW(6), .INIT(0), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .ld_val(ld_val),
    .bin(s_bin), .gray(s_gray), .wrap(s_wrap), .at_max(s_at_max), .at_min(s_at_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let the edge pass and settle before checking.
  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic l, input logic [5:0] v);
    rst    = r;
    en     = e;
    up     = u;
    ld     = l;
    ld_val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference step for one counter flavour; returns {wrap, bin}.
  function automatic logic [6:0] modelStep(input logic [5:0] cur, input logic r, input logic e,
                                           input logic u, input logic l, input logic [5:0] v,
                                           input logic sat);
    if (r) return {1'b0, 6'd0};
    if (l) return {1'b0, v};
    if (!e) return {1'b0, cur};
    if (u) begin
      if (cur == 6'd63) return sat ? {1'b0, 6'd63} : {1'b1, 6'd0};
      return {1'b0, cur + 6'd1};
    end
    if (cur == 6'd0) return sat ? {1'b0, 6'd0} : {1'b1, 6'd63};
    return {1'b0, cur - 6'd1};
  endfunction

  initial begin
    logic [5:0] m_w, m_s, prev_w_gray, prev_s_gray, rv;
    logic [6:0] nx;
    logic       r_r, r_e, r_u, r_l;
    int         exp_hd_w, exp_hd_s;

    rst = 1'b1; en = 1'b0; up = 1'b0; ld = 1'b0; ld_val = '0;

    // Reset
    applyStimulus(1, 0, 0, 0, 6'd0);
    applyStimulus(1, 0, 0, 0, 6'd0);
    checkOutput("rst_bin", 32'(w_bin), 32'd0);
    checkOutput("rst_gray", 32'(w_gray), 32'd0);
    checkOutput("rst_wrap", 32'(w_wrap), 32'd0);
    checkOutput("rst_at_min", 32'(w_at_min), 32'd1);
    checkOutput("rst_at_max", 32'(w_at_max), 32'd0);
    checkOutput("rst_sat_bin", 32'(s_bin), 32'd0);

    // Up wrap
    applyStimulus(0, 0, 1, 1, 6'd62);
    checkOutput("upw_ld_bin", 32'(w_bin), 32'd62);
    checkOutput("upw_ld_gray", 32'(w_gray), 32'b100001);
    applyStimulus(0, 1, 1, 0, 6'd0);
    checkOutput("upw_63_bin", 32'(w_bin), 32'd63);
    checkOutput("upw_63_gray", 32'(w_gray), 32'b100000);
    checkOutput("upw_63_at_max", 32'(w_at_max), 32'd1);
    checkOutput("upw_63_wrap", 32'(w_wrap), 32'd0);
    applyStimulus(0, 1, 1, 0, 6'd0);
    checkOutput("upw_0_bin", 32'(w_bin), 32'd0);
    checkOutput("upw_0_gray", 32'(w_gray), 32'd0);
    checkOutput("upw_0_wrap", 32'(w_wrap), 32'd1);
    applyStimulus(0, 0, 1, 0, 6'd0);
    checkOutput("upw_hold_wrap", 32'(w_wrap), 32'd0);
    checkOutput("upw_hold_bin", 32'(w_bin), 32'd0);

    // Down wrap
    applyStimulus(0, 0, 0, 1, 6'd0);
    checkOutput("dnw_ld_bin", 32'(w_bin), 32'd0);
    applyStimulus(0, 1, 0, 0, 6'd0);
    checkOutput("dnw_63_bin", 32'(w_bin), 32'd63);
    checkOutput("dnw_63_gray", 32'(w_gray), 32'b100000);
    checkOutput("dnw_63_wrap", 32'(w_wrap), 32'd1);
    applyStimulus(0, 1, 0, 0, 6'd0);
    checkOutput("dnw_62_bin", 32'(w_bin), 32'd62);
    checkOutput("dnw_62_gray", 32'(w_gray), 32'b100001);
    checkOutput("dnw_62_wrap", 32'(w_wrap), 32'd0);

    // Saturating instance up from 61 for 5 steps, then down from 0
    applyStimulus(0, 0, 1, 1, 6'd61);
    checkOutput("sat_ld_gray", 32'(s_gray), 32'b100011);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 1, 0, 6'd0);
      checkOutput("sat_up_bin", 32'(s_bin), (i == 0) ? 32'd62 : 32'd63);
      checkOutput("sat_up_wrap", 32'(s_wrap), 32'd0);
    end
    checkOutput("sat_up_gray", 32'(s_gray), 32'b100000);
    checkOutput("sat_up_at_max", 32'(s_at_max), 32'd1);
    applyStimulus(0, 0, 0, 1, 6'd0);
    applyStimulus(0, 1, 0, 0, 6'd0);
    checkOutput("sat_dn_bin", 32'(s_bin), 32'd0);
    checkOutput("sat_dn_wrap", 32'(s_wrap), 32'd0);

    // Load priority over enable, and reset priority over load
    applyStimulus(0, 1, 1, 1, 6'd45);
    checkOutput("ldpri_bin", 32'(w_bin), 32'd45);
    checkOutput("ldpri_gray", 32'(w_gray), 32'b111011);
    checkOutput("ldpri_wrap", 32'(w_wrap), 32'd0);
    applyStimulus(1, 1, 1, 1, 6'd45);
    checkOutput("rstpri_bin", 32'(w_bin), 32'd0);
    checkOutput("rstpri_gray", 32'(w_gray), 32'd0);

    // Reset on what would otherwise be a wrapping step leaves no pulse
    applyStimulus(0, 0, 1, 1, 6'd63);
    applyStimulus(1, 1, 1, 0, 6'd0);
    checkOutput("rstwrap_bin", 32'(w_bin), 32'd0);
    checkOutput("rstwrap_wrap", 32'(w_wrap), 32'd0);

    // Random traffic against a reference model for both flavours
    m_w = w_bin;
    m_s = s_bin;
    for (int c = 0; c < 2000; c++) begin
      r_r = ($urandom_range(63) == 0);
      r_e = ($urandom_range(3) != 0);
      r_u = $urandom_range(1) == 1;
      r_l = ($urandom_range(7) == 0);
      rv  = 6'($urandom_range(63));
      prev_w_gray = w_gray;
      prev_s_gray = s_gray;
      nx = modelStep(m_w, r_r, r_e, r_u, r_l, rv, 1'b0);
      exp_hd_w = (nx[5:0] == m_w) ? 0 : 1;
      m_w = nx[5:0];
      applyStimulus(r_r, r_e, r_u, r_l, rv);
      checkOutput("rnd_w_bin", 32'(w_bin), 32'(m_w));
      checkOutput("rnd_w_wrap", 32'(w_wrap), 32'(nx[6]));
      checkOutput("rnd_w_gray", 32'(w_gray), 32'(m_w ^ (m_w >> 1)));
      checkOutput("rnd_w_g2b", gray2bin(32'(w_gray)), 32'(m_w));
      if (!r_r && !r_l)
        checkOutput("rnd_w_hd", 32'($countones(prev_w_gray ^ w_gray)), 32'(exp_hd_w));
      nx = modelStep(m_s, r_r, r_e, r_u, r_l, rv, 1'b1);
      exp_hd_s = (nx[5:0] == m_s) ? 0 : 1;
      m_s = nx[5:0];
      checkOutput("rnd_s_bin", 32'(s_bin), 32'(m_s));
      checkOutput("rnd_s_wrap", 32'(s_wrap), 32'd0);
      checkOutput("rnd_s_gray", 32'(s_gray), 32'(m_s ^ (m_s >> 1)));
      if (!r_r && !r_l)
        checkOutput("rnd_s_hd", 32'($countones(prev_s_gray ^ s_gray)), 32'(exp_hd_s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
